// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
//
// Register-file write-back arbiter. ALU results are always accepted and win
// the single write port. Load results are queued in a small FIFO and written
// in arrival order whenever the ALU is idle. A per-register scoreboard
// (pending) tracks loads that have been issued but not yet written back.
//
// Ports
//   clk, reset               rising-edge clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data ALU result, no backpressure
//   mem_valid/mem_ready       load result handshake (ready = buffer not full)
//   mem_rd/mem_data           load result destination and data
//   pend_set/pend_rd          load issued: mark destination pending
//   reg_write/addr/write_reg  registered register-file write port
//   pending                   one bit per register, set while a load is out
//   fifo_count                number of buffered load results
// ---------------------------------------------------------------------------
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [31:0]              mem_data,
  input  logic                     pend_set,
  input  logic [4:0]               pend_rd,
  output logic                     reg_write,
  output logic [4:0]               addr,
  output logic [31:0]              write_reg,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Load-result storage; pointers wrap naturally because DEPTH is 2**PW.
  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          push;
  logic          pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic          sel_valid;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;
  logic [31:0]   pend_next;

  assign mem_ready = (fifo_count != CW'(DEPTH));

  // NOTE: every signal gets a value at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    push      = mem_valid && mem_ready;
    // The buffer is only drained when the ALU leaves the port free; a load
    // accepted this cycle is not visible at the head until the next one.
    pop       = !alu_valid && (fifo_count != '0);
    head_rd   = rd_mem[rd_ptr];
    head_data = data_mem[rd_ptr];

    sel_valid = alu_valid || pop;
    sel_rd    = alu_valid ? alu_rd   : head_rd;
    sel_data  = alu_valid ? alu_data : head_data;

    // Clear first, then set, so a same-cycle set on the same bit wins.
    pend_next = pending;
    if (pop)
      pend_next[head_rd] = 1'b0;
    if (pend_set)
      pend_next[pend_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write  <= 1'b0;
      addr       <= '0;
      write_reg  <= '0;
      pending    <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      // A selected rd=0 still consumes its slot but never writes x0.
      reg_write <= sel_valid && (sel_rd != 5'd0);
      if (sel_valid) begin
        addr      <= sel_rd;
        write_reg <= sel_data;
      end

      pending <= pend_next;

      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read behind
  // the pointers, and resetting the pointers discards them.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= mem_rd;
      data_mem[wr_ptr] <= mem_data;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback
//
// Self-checking bench for reg_writeback (DEPTH = 4): a table of directed
// vectors from reset, hand-written multi-cycle sequences (ALU conflict,
// full buffer, reset mid-drain), then randomized traffic compared against a
// queue-based reference model.
// ---------------------------------------------------------------------------
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        pend_set;
  logic [4:0]  pend_rd;
  logic        reg_write;
  logic [4:0]  addr;
  logic [31:0] write_reg;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .pend_set   (pend_set),
    .pend_rd    (pend_rd),
    .reg_write  (reg_write),
    .addr       (addr),
    .write_reg  (write_reg),
    .pending    (pending),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // ------------------------------------------------------------------------
  // Reference model: a plain queue of load results plus the expected
  // write-port registers and scoreboard.
  // ------------------------------------------------------------------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_pend;

  function automatic void model_step();
    ent_t e;
    bit   accept;
    if (reset) begin
      m_q.delete();
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_pend = '0;
      return;
    end
    accept = mem_valid && (m_q.size() < DEPTH);
    m_we   = 1'b0;
    if (alu_valid) begin
      m_we   = (alu_rd != 0);
      m_addr = alu_rd;
      m_data = alu_data;
    end else if (m_q.size() > 0) begin
      e      = m_q.pop_front();
      m_we   = (e.rd != 0);
      m_addr = e.rd;
      m_data = e.data;
      m_pend[e.rd] = 1'b0;
    end
    if (pend_set && pend_rd != 0)
      m_pend[pend_rd] = 1'b1;
    if (accept) begin
      e.rd   = mem_rd;
      e.data = mem_data;
      m_q.push_back(e);
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                        input logic ps, input logic [4:0] prd);
    alu_valid = av;  alu_rd = ard;  alu_data = adat;
    mem_valid = mv;  mem_rd = mrd;  mem_data = mdat;
    pend_set  = ps;  pend_rd = prd;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".reg_write"},  32'(reg_write),  32'(m_we));
    check({tag, ".addr"},       32'(addr),       32'(m_addr));
    check({tag, ".write_reg"},  write_reg,       m_data);
    check({tag, ".pending"},    pending,         m_pend);
    check({tag, ".fifo_count"}, 32'(fifo_count), 32'(m_q.size()));
    check({tag, ".mem_ready"},  32'(mem_ready),  32'(m_q.size() != DEPTH));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ------------------------------------------------------------------------
  // Directed vector table: inputs for one cycle and the outputs expected
  // after the following rising edge.
  // ------------------------------------------------------------------------
  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        ps;
    logic [4:0]  prd;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_pend;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // ALU-only write
    vecs[0]  = '{1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'h0,         0, 5'd0, 1, 5'd5, 32'h1234_5678, 32'h0000_0000, 3'd0};
    // load to x7 issued: pending[7] set, port holds
    vecs[1]  = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd7, 0, 5'd5, 32'h1234_5678, 32'h0000_0080, 3'd0};
    // load result arrives: buffered, no bypass
    vecs[2]  = '{0, 5'd0, 32'h0,         1, 5'd7, 32'hCAFE_F00D, 0, 5'd0, 0, 5'd5, 32'h1234_5678, 32'h0000_0080, 3'd1};
    // written from the buffer two cycles after acceptance, pending cleared
    vecs[3]  = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 1, 5'd7, 32'hCAFE_F00D, 32'h0000_0000, 3'd0};
    // idle: write disabled, port data held
    vecs[4]  = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 0, 5'd7, 32'hCAFE_F00D, 32'h0000_0000, 3'd0};
    // ALU write to x0 suppressed
    vecs[5]  = '{1, 5'd0, 32'hDEAD_BEEF, 0, 5'd0, 32'h0,         0, 5'd0, 0, 5'd0, 32'hDEAD_BEEF, 32'h0000_0000, 3'd0};
    // pend_rd = 0 ignored; load to x3 buffered (x3 not yet pending)
    vecs[6]  = '{0, 5'd0, 32'h0,         1, 5'd3, 32'h0000_0033, 1, 5'd0, 0, 5'd0, 32'hDEAD_BEEF, 32'h0000_0000, 3'd1};
    // new load to x3 issued the same cycle the buffered x3 load is written
    vecs[7]  = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd3, 1, 5'd3, 32'h0000_0033, 32'h0000_0008, 3'd0};
    // pending[3] survives; ALU write to x3 must not touch it
    vecs[8]  = '{1, 5'd3, 32'h0000_0099, 0, 5'd0, 32'h0,         0, 5'd0, 1, 5'd3, 32'h0000_0099, 32'h0000_0008, 3'd0};
    // load to x0 buffered
    vecs[9]  = '{0, 5'd0, 32'h0,         1, 5'd0, 32'h0000_0044, 0, 5'd0, 0, 5'd3, 32'h0000_0099, 32'h0000_0008, 3'd1};
    // load to x0 drained without a write
    vecs[10] = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 0, 5'd0, 32'h0000_0044, 32'h0000_0008, 3'd0};
  end

  initial begin
    string tag;
    reset = 1'b0;
    idle();
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    check("rst.reg_write",  32'(reg_write),  32'd0);
    check("rst.addr",       32'(addr),       32'd0);
    check("rst.write_reg",  write_reg,       32'd0);
    check("rst.pending",    pending,         32'd0);
    check("rst.fifo_count", 32'(fifo_count), 32'd0);
    check("rst.mem_ready",  32'(mem_ready),  32'd1);

    // ---- table-driven vectors ----
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv, vecs[i].mrd,
             vecs[i].mdat, vecs[i].ps, vecs[i].prd);
      tick();
      tag = $sformatf("vec%0d", i);
      check({tag, ".reg_write"},  32'(reg_write),  32'(vecs[i].e_we));
      check({tag, ".addr"},       32'(addr),       32'(vecs[i].e_addr));
      check({tag, ".write_reg"},  write_reg,       vecs[i].e_data);
      check({tag, ".pending"},    pending,         vecs[i].e_pend);
      check({tag, ".fifo_count"}, 32'(fifo_count), 32'(vecs[i].e_cnt));
      check({tag, ".mem_ready"},  32'(mem_ready),  32'(vecs[i].e_cnt != 3'd4));
    end
    idle();

    // ---- ALU conflict: one buffered load waits behind three ALU writes ----
    do_reset();
    set_in(0, 5'd0, 32'd0, 1, 5'd9, 32'hA0A0_0009, 0, 5'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 5'(10 + i), 32'(32'hB000_0000 + i), 0, 5'd0, 32'd0, 0, 5'd0);
      tick();
      check($sformatf("conf%0d.addr", i),       32'(addr),       32'(10 + i));
      check($sformatf("conf%0d.reg_write", i),  32'(reg_write),  32'd1);
      check($sformatf("conf%0d.fifo_count", i), 32'(fifo_count), 32'd1);
    end
    idle();
    tick();
    check("conf.load_addr", 32'(addr), 32'd9);
    check("conf.load_data", write_reg, 32'hA0A0_0009);
    check("conf.load_we",   32'(reg_write), 32'd1);
    check("conf.drained",   32'(fifo_count), 32'd0);

    // ---- full buffer while ALU busy, then in-order drain ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 5'd20, 32'h2020_2020, 1, 5'(i + 1), 32'(32'h100 + i), 0, 5'd0);
      tick();
    end
    check("full.mem_ready",  32'(mem_ready),  32'd0);
    check("full.fifo_count", 32'(fifo_count), 32'd4);
    // offered load while full must be refused
    set_in(1, 5'd21, 32'h2121_2121, 1, 5'd30, 32'hBAD0_BAD0, 0, 5'd0);
    tick();
    check("full.refused", 32'(fifo_count), 32'd4);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("drain%0d.addr", i), 32'(addr),      32'(i + 1));
      check($sformatf("drain%0d.data", i), write_reg,      32'(32'h100 + i));
      check($sformatf("drain%0d.we", i),   32'(reg_write), 32'd1);
    end
    tick();
    check("drain.empty_we",    32'(reg_write),  32'd0);
    check("drain.empty_count", 32'(fifo_count), 32'd0);

    // ---- reset mid-drain with two entries buffered ----
    do_reset();
    set_in(1, 5'd1, 32'h1, 1, 5'd11, 32'h1111_1111, 1, 5'd11);
    tick();
    set_in(1, 5'd2, 32'h2, 1, 5'd12, 32'h1212_1212, 1, 5'd12);
    tick();
    idle();
    tick();
    check("middrain.count_before", 32'(fifo_count), 32'd1);
    set_in(0, 5'd0, 32'd0, 1, 5'd13, 32'h1313_1313, 0, 5'd0);
    tick();
    check("middrain.count_two", 32'(fifo_count), 32'd1 + 32'd1 - 32'd1);
    set_in(1, 5'd4, 32'h4, 1, 5'd14, 32'h1414_1414, 0, 5'd0);
    tick();
    check("middrain.count_pre", 32'(fifo_count), 32'd2);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("middrain.reg_write",  32'(reg_write),  32'd0);
    check("middrain.fifo_count", 32'(fifo_count), 32'd0);
    check("middrain.pending",    pending,         32'd0);
    check("middrain.mem_ready",  32'(mem_ready),  32'd1);
    tick();
    check("middrain.no_write",   32'(reg_write),  32'd0);

    // ---- randomized traffic against the reference model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      alu_valid = ($urandom_range(0, 99) < 45);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      mem_valid = ($urandom_range(0, 99) < 60);
      mem_rd    = 5'($urandom_range(0, 7));
      mem_data  = $urandom;
      pend_set  = ($urandom_range(0, 99) < 35);
      pend_rd   = 5'($urandom_range(0, 7));
      reset     = ($urandom_range(0, 199) == 0);
      tick();
      check_model($sformatf("rand%0d", c));
    end
    reset = 1'b0;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
